// File: rtl/packet_filter_pkg.sv
// Shared types and helpers for the packet filter buffer.
package packet_filter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    DROP = 2'd2
  } wr_state_t;

  // Empty-field width for a given data width; never narrower than one bit.
  function automatic int unsigned empty_width(input int unsigned dwidth);
    return (dwidth > 8) ? $clog2(dwidth / 8) : 1;
  endfunction

  localparam int unsigned DEF_DWIDTH = 64;
  localparam int unsigned DEF_EWIDTH = empty_width(DEF_DWIDTH);

  // Buffer word layout for the default 64-bit configuration.
  typedef struct packed {
    logic                  sop;
    logic                  eop;
    logic [DEF_EWIDTH-1:0] empty;
    logic [DEF_DWIDTH-1:0] data;
  } mem_word_t;

  // Saturating 32-bit add of a small increment.
  function automatic logic [31:0] sat_add(input logic [31:0] cnt, input logic [1:0] inc);
    logic [32:0] sum;
    sum = {1'b0, cnt} + 33'(inc);
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/pfb_ram.sv
// Simple dual-port packet store: one write port, one registered read port.
module pfb_ram #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned AWIDTH = 4
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              re,
  input  logic [AWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** AWIDTH;

  logic [DWIDTH-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; holds its value when not reading so it can act as the output stage.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/packet_filter_buffer.sv
// Store-and-forward packet filter: buffers each packet and forwards it only if
// any beat was classified as a match. Optional counters: PKT_FILTER_STATS_EN.
module packet_filter_buffer
  import packet_filter_pkg::*;
#(
  parameter int unsigned AST_DWIDTH    = 64,
  parameter int unsigned CHANNEL_WIDTH = 1,
  parameter int unsigned MEM_AWIDTH    = 8,
  localparam int unsigned EMPTY_WIDTH  = empty_width(AST_DWIDTH)
) (
  input  logic                     clk_i,
  input  logic                     srst_i,
  input  logic [AST_DWIDTH-1:0]    sink_data_i,
  input  logic                     sink_valid_i,
  input  logic                     sink_startofpacket_i,
  input  logic                     sink_endofpacket_i,
  input  logic [EMPTY_WIDTH-1:0]   sink_empty_i,
  input  logic [CHANNEL_WIDTH-1:0] sink_channel_i,
  output logic                     sink_ready_o,
  output logic [AST_DWIDTH-1:0]    src_data_o,
  output logic                     src_startofpacket_o,
  output logic                     src_endofpacket_o,
  output logic [EMPTY_WIDTH-1:0]   src_empty_o,
  output logic                     src_valid_o,
`ifdef PKT_FILTER_STATS_EN
  output logic [31:0]              fwd_cnt_o,
  output logic [31:0]              drop_cnt_o,
  output logic [31:0]              ovf_cnt_o,
`endif
  input  logic                     src_ready_i
);

  localparam int unsigned WORD_W = AST_DWIDTH + EMPTY_WIDTH + 2;
  localparam logic [MEM_AWIDTH-1:0] PTR_ONE = MEM_AWIDTH'(1);

  wr_state_t             state_q, state_d;
  logic [MEM_AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [MEM_AWIDTH-1:0] commit_q, commit_d;
  logic [MEM_AWIDTH-1:0] rd_ptr_q;
  logic [MEM_AWIDTH-1:0] waddr;
  logic                  match_q, match_d;
  logic                  sink_ready_q;
  logic                  src_valid_q;
  logic                  accept, beat_match, wr_full, sop_full, we, rd_en;
  logic [WORD_W-1:0]     wdata, rdata;
`ifdef PKT_FILTER_STATS_EN
  logic [1:0]            drop_inc, ovf_inc;
`endif

  assign accept     = sink_valid_i & sink_ready_q;
  assign beat_match = |sink_channel_i;
  assign wr_full    = (wr_ptr_q + PTR_ONE) == rd_ptr_q;
  assign sop_full   = (commit_q + PTR_ONE) == rd_ptr_q;
  assign wdata      = {sink_startofpacket_i, sink_endofpacket_i, sink_empty_i, sink_data_i};

  // Write FSM next state, pointer updates and buffer write strobe.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    commit_d = commit_q;
    match_d  = match_q;
    we       = 1'b0;
    waddr    = wr_ptr_q;
`ifdef PKT_FILTER_STATS_EN
    drop_inc = 2'd0;
    ovf_inc  = 2'd0;
`endif
    if (accept && sink_startofpacket_i) begin
      // New packet always restarts at the commit point, abandoning any open one.
`ifdef PKT_FILTER_STATS_EN
      if (state_q == WR)   drop_inc = 2'd1;
      if (state_q == DROP) ovf_inc  = 2'd1;
`endif
      waddr    = commit_q;
      match_d  = beat_match;
      wr_ptr_d = commit_q;
      if (sop_full) begin
        state_d = sink_endofpacket_i ? IDLE : DROP;
`ifdef PKT_FILTER_STATS_EN
        if (sink_endofpacket_i) ovf_inc = ovf_inc + 2'd1;
`endif
      end else begin
        we = 1'b1;
        if (!sink_endofpacket_i) begin
          state_d  = WR;
          wr_ptr_d = commit_q + PTR_ONE;
        end else begin
          state_d = IDLE;
          if (beat_match) begin
            commit_d = commit_q + PTR_ONE;
            wr_ptr_d = commit_q + PTR_ONE;
          end
`ifdef PKT_FILTER_STATS_EN
          if (!beat_match) drop_inc = drop_inc + 2'd1;
`endif
        end
      end
    end else if (accept) begin
      case (state_q)
        WR: begin
          if (wr_full) begin
            wr_ptr_d = commit_q;
            state_d  = sink_endofpacket_i ? IDLE : DROP;
`ifdef PKT_FILTER_STATS_EN
            if (sink_endofpacket_i) ovf_inc = 2'd1;
`endif
          end else begin
            we       = 1'b1;
            match_d  = match_q | beat_match;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (sink_endofpacket_i) begin
              state_d = IDLE;
              if (match_q | beat_match) commit_d = wr_ptr_q + PTR_ONE;
              else                      wr_ptr_d = commit_q;
`ifdef PKT_FILTER_STATS_EN
              if (!(match_q | beat_match)) drop_inc = 2'd1;
`endif
            end
          end
        end
        DROP: begin
          if (sink_endofpacket_i) begin
            state_d = IDLE;
`ifdef PKT_FILTER_STATS_EN
            ovf_inc = 2'd1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // Write-side state registers; sink_ready rises on the first edge after reset.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      commit_q     <= '0;
      match_q      <= 1'b0;
      sink_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_q     <= commit_d;
      match_q      <= match_d;
      sink_ready_q <= 1'b1;
    end
  end

  // Fetch the next committed word whenever the output stage is empty or draining.
  assign rd_en = (rd_ptr_q != commit_q) && (!src_valid_q || src_ready_i);

  // Read pointer and output-valid flag for the show-ahead stage.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      rd_ptr_q    <= '0;
      src_valid_q <= 1'b0;
    end else if (rd_en) begin
      rd_ptr_q    <= rd_ptr_q + PTR_ONE;
      src_valid_q <= 1'b1;
    end else if (src_ready_i) begin
      src_valid_q <= 1'b0;
    end
  end

  pfb_ram #(
    .DWIDTH (WORD_W),
    .AWIDTH (MEM_AWIDTH)
  ) u_ram (
    .clk_i  (clk_i),
    .srst_i (srst_i),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .re     (rd_en),
    .raddr  (rd_ptr_q),
    .rdata  (rdata)
  );

  assign {src_startofpacket_o, src_endofpacket_o, src_empty_o, src_data_o} = rdata;
  assign src_valid_o  = src_valid_q;
  assign sink_ready_o = sink_ready_q;

`ifdef PKT_FILTER_STATS_EN
  // Saturating packet outcome counters.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      fwd_cnt_o  <= '0;
      drop_cnt_o <= '0;
      ovf_cnt_o  <= '0;
    end else begin
      fwd_cnt_o  <= sat_add(fwd_cnt_o, {1'b0, commit_d != commit_q});
      drop_cnt_o <= sat_add(drop_cnt_o, drop_inc);
      ovf_cnt_o  <= sat_add(ovf_cnt_o, ovf_inc);
    end
  end
`endif

endmodule
